reg_wb_ctrl: RTL and testbench
==============================

Name: reg_wb_ctrl

Overview:
- Initiator side of the register-file write port: arbitrates ALU results and load returns and drives RegWrite/WN/WD.
- Loads buffer in a small FIFO. ALU writes are never stalled.
- Keeps a pending-load scoreboard so decode can stall on RAW hazards against outstanding loads.
- One instance per core, between execute/memory stages and the register file.

Parameters:
- DEPTH, 4, load-return FIFO entries (power of two, ≥2).
- CORE_ID, 0, core number printed in trace messages.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result this cycle (no ready; always accepted).
- alu_wn  in  5  ALU destination register.
- alu_wd  in  32  ALU result data.
- ld_valid  in  1  load return offered.
- ld_ready  out  1  load return accepted when ld_valid && ld_ready.
- ld_wn  in  5  load destination register.
- ld_wd  in  32  load data.
- ld_issue  in  1  load issued to memory this cycle.
- ld_issue_wn  in  5  destination of issued load.
- rs  in  5  decode source register 1.
- rt  in  5  decode source register 2.
- rs_pending  out  1  pending[rs], combinational.
- rt_pending  out  1  pending[rt], combinational.
- wb_stall  out  1  FIFO full; pipeline must hold the load issue.
- RegWrite  out  1  register-file write enable, registered.
- WN  out  5  write register number, registered.
- WD  out  32  write data, registered.

Behaviour:
- Reset (async, immediate):
  - RegWrite=0, WN=0, WD=0.
  - FIFO empty, so ld_ready=1 and wb_stall=0.
  - pending = 0.
- ld_ready = !full; wb_stall = full. Both depend only on occupancy, not on a same-cycle pop.
- Push: on posedge with ld_valid && ld_ready. The entry stores {wn, wd}. Pointers wrap modulo DEPTH. Occupancy count is clog2(DEPTH+1) bits.
- Arbitration, evaluated each posedge:
  - If alu_valid && alu_wn!=0: RegWrite<=1, WN<=alu_wn, WD<=alu_wd. FIFO is not popped.
  - Else if FIFO not empty: pop head; RegWrite<=1, WN<=head.wn, WD<=head.wd.
  - Else: RegWrite<=0. WN and WD hold their previous values.
- alu_valid with alu_wn==0 is a no-op and does not block the FIFO pop.
- Loads to register 0 are accepted into the FIFO and popped normally, but drive RegWrite<=0. They do not touch pending.
- Latency: an ALU write is presented one edge after alu_valid and lands in the register file on the following edge.
- The FIFO read path is combinational from the head entry. A push to an empty FIFO can be popped on the next edge, never the same edge.
- Simultaneous push and pop when full: the pop happens, the push is refused (ld_ready was 0).
- Scoreboard:
  - ld_issue && ld_issue_wn!=0 sets pending[ld_issue_wn].
  - A pop with head.wn!=0 clears pending[head.wn] at the same edge RegWrite is driven.
  - Same register set and cleared on one edge: set wins.
  - pending[0] is always 0.
- Ordering: load returns to the same register write in arrival order. The ALU-vs-load order is the issuing pipeline's responsibility, enforced via the scoreboard.

Optional Feature:
- WB_TRACE_EN defined: every edge with RegWrite asserting prints $time, CORE_ID, WN, WD and the source (ALU/LOAD). Every FIFO push prints its wn and wd.
- Undefined: no $display statements are compiled; logic is identical.

Decomposition:
- Package reg_wb_pkg:
  - REG_ADDR_W=5, DATA_W=32.
  - Packed struct wb_entry_t {wn, wd}.
  - Enum wb_src_t {WB_NONE, WB_ALU, WB_LOAD} for trace/debug.
- Sub-module wb_fifo:
  - Parameterised by DEPTH; holds wb_entry_t.
  - Ports: push, pop, full, empty, head.
  - Same clk and async active-high reset.

Test Plan:
- Reset mid-operation: 3 entries queued, RegWrite=1, then reset pulse → outputs 0 immediately, ld_ready=1, pending=0, no write after release.
- ALU only: alu_valid, alu_wn=5, alu_wd=0x1234 → next edge RegWrite=1, WN=5, WD=0x1234; following cycle with alu_valid=0 and FIFO empty → RegWrite=0.
- Priority: load {7, 0xAA} queued while alu_valid for 3 cycles to regs 1,2,3 → writes 1,2,3 then 7; pending[7] clears on the edge WN=7 is driven.
- Full FIFO: issue 4 loads to regs 8..11, return all with ALU busy → wb_stall=1 and ld_ready=0. A 5th ld_valid is not accepted until the first pop. Pointer wrap is verified by 8 further push/pop cycles with in-order data.
- Scoreboard collision: pending[9] set, return to 9 popped on the same edge ld_issue with wn=9 → pending[9] stays 1. rs=9 gives rs_pending=1; rt=0 gives rt_pending=0.
- Register 0: ALU and load writes to r0 → RegWrite never asserts for them; the FIFO still drains and the ALU no-op lets the FIFO pop.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file write-back controller: entry format, source tags
// and a helper that turns a register number into a pending-mask bit.
package reg_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wn;
        logic [DATA_W-1:0]     wd;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD
    } wb_src_t;

    // r0 is hard-wired, so it never gets a scoreboard bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != '0) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-return FIFO holding wb_entry_t. Head is read combinationally; DEPTH must be a
// power of two so the pointers wrap naturally.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output wb_entry_t head_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    wb_entry_t         mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port initiator: ALU results win, buffered load returns fill idle
// slots, and a pending-load scoreboard feeds decode. Define WB_TRACE_EN for write/push trace.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CORE_ID = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_wn,
    input  logic [DATA_W-1:0]     alu_wd,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_wn,
    input  logic [DATA_W-1:0]     ld_wd,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_wn,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  rs_pending,
    output logic                  rt_pending,
    output logic                  wb_stall,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WN,
    output logic [DATA_W-1:0]     WD
);

    wb_entry_t             push_entry, head;
    logic                  full, empty;
    logic                  do_push, do_pop, alu_take;
    logic                  regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0] wn_q, wn_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    assign ld_ready = !full;
    assign wb_stall = full;

    assign push_entry.wn = ld_wn;
    assign push_entry.wd = ld_wd;

    assign do_push  = ld_valid && !full;
    assign alu_take = alu_valid && (alu_wn != '0);
    assign do_pop   = !alu_take && !empty;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (do_push),
        .push_data_i(push_entry),
        .pop_i      (do_pop),
        .full_o     (full),
        .empty_o    (empty),
        .head_o     (head)
    );

    // WN/WD only move on a real write; r0 load pops leave them untouched.
    always_comb begin
        regwrite_d = 1'b0;
        wn_d       = wn_q;
        wd_d       = wd_q;
        if (alu_take) begin
            regwrite_d = 1'b1;
            wn_d       = alu_wn;
            wd_d       = alu_wd;
        end else if (do_pop && (head.wn != '0)) begin
            regwrite_d = 1'b1;
            wn_d       = head.wn;
            wd_d       = head.wd;
        end
    end

    // Clear before set so a same-edge issue to the retiring register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (do_pop) begin
            pending_d = pending_d & ~reg_onehot(head.wn);
        end
        if (ld_issue) begin
            pending_d = pending_d | reg_onehot(ld_issue_wn);
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            wn_q       <= '0;
            wd_q       <= '0;
            pending_q  <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wn_q       <= wn_d;
            wd_q       <= wd_d;
            pending_q  <= pending_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign WN         = wn_q;
    assign WD         = wd_q;
    assign rs_pending = pending_q[rs];
    assign rt_pending = pending_q[rt];

`ifdef WB_TRACE_EN
    wb_src_t trace_src;

    always_comb begin
        trace_src = WB_NONE;
        if (alu_take) begin
            trace_src = WB_ALU;
        end else if (regwrite_d) begin
            trace_src = WB_LOAD;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (regwrite_d) begin
                $display("[%0t] core%0d WB %s wn=%0d wd=%08h", $time, CORE_ID,
                         trace_src.name(), wn_d, wd_d);
            end
            if (do_push) begin
                $display("[%0t] core%0d PUSH wn=%0d wd=%08h", $time, CORE_ID, ld_wn, ld_wd);
            end
        end
    end
`else
    logic unused_core_id;
    assign unused_core_id = ^CORE_ID;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: a reference model predicts each edge's write and
// scoreboard state, queues the expectation, and compares once the DUT has clocked.
module tb_reg_wb_ctrl;
    import reg_wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid, ld_issue;
    logic [4:0]  alu_wn, ld_wn, ld_issue_wn, rs, rt;
    logic [31:0] alu_wd, ld_wd;
    logic        ld_ready, rs_pending, rt_pending, wb_stall, RegWrite;
    logic [4:0]  WN;
    logic [31:0] WD;

    always #5 clk = ~clk;

    reg_wb_ctrl #(
        .DEPTH  (DEPTH),
        .CORE_ID(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_wn     (alu_wn),
        .alu_wd     (alu_wd),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_wn      (ld_wn),
        .ld_wd      (ld_wd),
        .ld_issue   (ld_issue),
        .ld_issue_wn(ld_issue_wn),
        .rs         (rs),
        .rt         (rt),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .wb_stall   (wb_stall),
        .RegWrite   (RegWrite),
        .WN         (WN),
        .WD         (WD)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wn;
        logic [31:0] wd;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    wb_entry_t   mq[$];
    exp_t        exp_q[$];
    logic [31:0] pm;
    logic [4:0]  wn_m;
    logic [31:0] wd_m;
    logic        acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        pm   = '0;
        wn_m = '0;
        wd_m = '0;
    endtask

    // One clock: drive, check combinational outputs, predict, clock, compare.
    task automatic step(input logic av, input logic [4:0] awn, input logic [31:0] awd,
                        input logic lv, input logic [4:0] lwn, input logic [31:0] lwd,
                        input logic iss, input logic [4:0] iwn, output logic accepted);
        exp_t      e;
        wb_entry_t hd, ne;
        logic      take, pop;
        @(negedge clk);
        alu_valid   = av;
        alu_wn      = awn;
        alu_wd      = awd;
        ld_valid    = lv;
        ld_wn       = lwn;
        ld_wd       = lwd;
        ld_issue    = iss;
        ld_issue_wn = iwn;
        #1;
        check_eq("ld_ready", ld_ready, (mq.size() < DEPTH));
        check_eq("wb_stall", wb_stall, (mq.size() == DEPTH));
        check_eq("rs_pending_pre", rs_pending, pm[rs]);
        check_eq("rt_pending_pre", rt_pending, pm[rt]);
        take     = av && (awn != 0);
        pop      = !take && (mq.size() > 0);
        accepted = lv && (mq.size() < DEPTH);
        e.we = 1'b0;
        if (take) begin
            e.we = 1'b1;
            wn_m = awn;
            wd_m = awd;
        end else if (pop) begin
            hd = mq.pop_front();
            if (hd.wn != 0) begin
                e.we = 1'b1;
                wn_m = hd.wn;
                wd_m = hd.wd;
                pm[hd.wn] = 1'b0;
            end
        end
        if (accepted) begin
            ne.wn = lwn;
            ne.wd = lwd;
            mq.push_back(ne);
        end
        if (iss && (iwn != 0)) pm[iwn] = 1'b1;
        e.wn = wn_m;
        e.wd = wd_m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("RegWrite", RegWrite, e.we);
        check_eq("WN", WN, e.wn);
        check_eq("WD", WD, e.wd);
        check_eq("rs_pending_post", rs_pending, pm[rs]);
        check_eq("rt_pending_post", rt_pending, pm[rt]);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {alu_valid, ld_valid, ld_issue} = '0;
        {alu_wn, ld_wn, ld_issue_wn, rs, rt} = '0;
        alu_wd = '0;
        ld_wd  = '0;
        model_clear();
        #12;
        check_eq("rst_RegWrite", RegWrite, 1'b0);
        check_eq("rst_WN", WN, 5'd0);
        check_eq("rst_WD", WD, 32'd0);
        check_eq("rst_ld_ready", ld_ready, 1'b1);
        check_eq("rst_wb_stall", wb_stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // ALU only
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, acc);
        check_eq("alu_WN5", WN, 5'd5);
        idle(1);
        check_eq("alu_idle_RegWrite", RegWrite, 1'b0);

        // ALU priority over a queued load
        rs = 7;
        rt = 1;
        step(0, 0, 0, 0, 0, 0, 1, 7, acc);
        step(1, 1, 32'h11, 1, 7, 32'hAA, 0, 0, acc);
        step(1, 2, 32'h22, 0, 0, 0, 0, 0, acc);
        step(1, 3, 32'h33, 0, 0, 0, 0, 0, acc);
        check_eq("prio_rs7_still_pending", rs_pending, 1'b1);
        idle(1);
        check_eq("prio_load_WN7", WN, 5'd7);
        check_eq("prio_rs7_cleared", rs_pending, 1'b0);
        idle(1);

        // Fill the FIFO while the ALU owns the port
        rs = 8;
        rt = 11;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 5'(8 + i), acc);
        for (int i = 0; i < 4; i++)
            step(1, 5'(1 + i), 32'(i), 1, 5'(8 + i), 32'(32'h100 + i), 0, 0, acc);
        check_eq("full_wb_stall", wb_stall, 1'b1);
        check_eq("full_ld_ready", ld_ready, 1'b0);
        step(1, 20, 32'h2020, 1, 12, 32'h200, 0, 0, acc);
        check_eq("full_refused", acc, 1'b0);
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) step(0, 0, 0, 1, 12, 32'h200, 0, 0, acc);
        check_eq("ld12_accepted", acc, 1'b1);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 1, 5'(13 + (i % 4)), $urandom, 0, 0, acc);
        idle(7);

        // Set/clear collision on r9
        rs = 9;
        rt = 0;
        step(0, 0, 0, 0, 0, 0, 1, 9, acc);
        step(0, 0, 0, 1, 9, 32'h99, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 1, 9, acc);
        check_eq("coll_WN9", WN, 5'd9);
        check_eq("coll_rs9_pending", rs_pending, 1'b1);
        check_eq("coll_rt0_pending", rt_pending, 1'b0);
        step(0, 0, 0, 1, 9, 32'h999, 0, 0, acc);
        idle(2);

        // r0 handling
        step(0, 0, 0, 0, 0, 0, 1, 0, acc);
        step(1, 0, 32'hDEAD, 1, 4, 32'h44, 0, 0, acc);
        step(1, 0, 32'hBEEF, 1, 0, 32'h55, 0, 0, acc);
        check_eq("r0_alu_noop_pop_WN4", WN, 5'd4);
        idle(1);
        check_eq("r0_load_no_write", RegWrite, 1'b0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rs = 5'($urandom);
            rt = 5'($urandom);
            step(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), acc);
        end
        idle(6);

        // Reset mid-operation
        rs = 3;
        rt = 6;
        step(0, 0, 0, 0, 0, 0, 1, 3, acc);
        step(1, 1, 32'h1, 1, 3, 32'h3, 1, 6, acc);
        step(1, 2, 32'h2, 1, 4, 32'h4, 0, 0, acc);
        step(1, 3, 32'h3, 1, 5, 32'h5, 0, 0, acc);
        check_eq("pre_rst_RegWrite", RegWrite, 1'b1);
        {alu_valid, ld_valid, ld_issue} = '0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("mrst_RegWrite", RegWrite, 1'b0);
        check_eq("mrst_WN", WN, 5'd0);
        check_eq("mrst_WD", WD, 32'd0);
        check_eq("mrst_ld_ready", ld_ready, 1'b1);
        check_eq("mrst_wb_stall", wb_stall, 1'b0);
        check_eq("mrst_rs_pending", rs_pending, 1'b0);
        check_eq("mrst_rt_pending", rt_pending, 1'b0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
